led_status: RTL and testbench

Multi-channel status-LED driver for board bring-up and run-time fault indication. It is the parametrised successor to the free-running LED heartbeat. Each of NUM_LEDS outputs independently shows one of several patterns:
- off / on
- slow or fast blink
- a numeric blink code
- an optional PWM "breathing" fade

All patterns run from one shared prescaler so that channels stay phase-aligned. The block sits at the top level between the control/status logic and the board LED pins.

---
 rtl/led_status.sv | 163 ++++++++++++++++
 tb/tb_led_status.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_status.sv
// led_status: multi-channel status-LED driver (off/on/slow/fast blink, blink code, breathe).
// Define LED_STATUS_BREATHE_EN to compile in the PWM breathing fade; otherwise mode 5 mirrors SLOW.
module led_status #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*NUM_LEDS-1:0] mode_i,
  input  logic [4*NUM_LEDS-1:0] code_i,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_SLOW    = 3'd2;
  localparam logic [2:0] MODE_FAST    = 3'd3;
  localparam logic [2:0] MODE_CODE    = 3'd4;
  localparam logic [2:0] MODE_BREATHE = 3'd5;

  typedef enum logic [1:0] {
    CODE_IDLE,
    CODE_ON,
    CODE_OFF,
    CODE_GAP
  } code_state_e;

  logic [PRE_W-1:0] presc;
  logic [7:0]       phase;
  logic             tick_c;
  logic             breathe_c;

  assign tick_c = (presc == PRE_LAST);

  // Shared prescaler, tick pulse and phase counter keep all channels aligned.
  always_ff @(posedge clk or negedge rst_n) begin : p_timebase
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
      phase <= '0;
    end else begin
      tick <= tick_c;
      if (tick_c) begin
        presc <= '0;
        phase <= phase + 8'd1;
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

`ifdef LED_STATUS_BREATHE_EN
  logic [6:0] pwm;
  logic [6:0] duty;

  // Free-running PWM carrier compared against a triangle duty taken from phase.
  always_ff @(posedge clk or negedge rst_n) begin : p_pwm
    if (!rst_n) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + 7'd1;
    end
  end

  assign duty      = phase[7] ? ~phase[6:0] : phase[6:0];
  assign breathe_c = (pwm < duty);
`else
  assign breathe_c = phase[7];
`endif

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_ch
    code_state_e state, state_nxt;
    logic [4:0]  tcnt, tcnt_nxt;
    logic [3:0]  pcnt, pcnt_nxt;
    logic [2:0]  mode;
    logic [3:0]  code;
    logic        led_q, led_nxt;

    assign mode   = mode_i[3*k +: 3];
    assign code   = code_i[4*k +: 4];
    assign led[k] = led_q;

    always_ff @(posedge clk or negedge rst_n) begin : p_state
      if (!rst_n) begin
        state <= CODE_IDLE;
        tcnt  <= '0;
        pcnt  <= '0;
        led_q <= 1'b0;
      end else begin
        state <= state_nxt;
        tcnt  <= tcnt_nxt;
        pcnt  <= pcnt_nxt;
        led_q <= led_nxt;
      end
    end

    // Blink-code sequencer advances only on tick; parked in IDLE outside CODE mode.
    always_comb begin : p_next
      state_nxt = state;
      tcnt_nxt  = tcnt;
      pcnt_nxt  = pcnt;
      led_nxt   = 1'b0;

      if (mode != MODE_CODE) begin
        state_nxt = CODE_IDLE;
        tcnt_nxt  = '0;
        pcnt_nxt  = '0;
      end else if (tick_c) begin
        case (state)
          CODE_IDLE: begin
            pcnt_nxt  = code;
            tcnt_nxt  = '0;
            state_nxt = (code == 4'd0) ? CODE_GAP : CODE_ON;
          end
          CODE_ON: begin
            if (tcnt == 5'd7) begin
              tcnt_nxt  = '0;
              state_nxt = CODE_OFF;
            end else begin
              tcnt_nxt = tcnt + 5'd1;
            end
          end
          CODE_OFF: begin
            if (tcnt == 5'd7) begin
              tcnt_nxt  = '0;
              pcnt_nxt  = pcnt - 4'd1;
              state_nxt = (pcnt > 4'd1) ? CODE_ON : CODE_GAP;
            end else begin
              tcnt_nxt = tcnt + 5'd1;
            end
          end
          CODE_GAP: begin
            if (tcnt == 5'd31) begin
              tcnt_nxt  = '0;
              state_nxt = CODE_IDLE;
            end else begin
              tcnt_nxt = tcnt + 5'd1;
            end
          end
          default: begin
            tcnt_nxt  = '0;
            state_nxt = CODE_IDLE;
          end
        endcase
      end

      case (mode)
        MODE_OFF:     led_nxt = 1'b0;
        MODE_ON:      led_nxt = 1'b1;
        MODE_SLOW:    led_nxt = phase[7];
        MODE_FAST:    led_nxt = phase[5];
        MODE_CODE:    led_nxt = (state == CODE_ON);
        MODE_BREATHE: led_nxt = breathe_c;
        default:      led_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status.sv
// Self-checking bench for led_status: scoreboard of expected {tick, led} per cycle across four configurations.
// Honours LED_STATUS_BREATHE_EN the same way the design does.
module tb_led_status;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
  logic [11:0] mode_a = '0;
  logic [15:0] code_a = '0;
  logic [3:0]  led_a;
  logic        tick_a;
  logic [17:0] mode_b = '0;
  logic [23:0] code_b = '0;
  logic [5:0]  led_b;
  logic        tick_b;
  logic [5:0]  mode_c = '0;
  logic [7:0]  code_c = '0;
  logic [1:0]  led_c;
  logic        tick_c;
  logic [2:0]  mode_d = '0;
  logic [3:0]  code_d = '0;
  logic [0:0]  led_d;
  logic        tick_d;

  led_status #(.NUM_LEDS(4), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .mode_i(mode_a), .code_i(code_a), .led(led_a), .tick(tick_a));
  led_status #(.NUM_LEDS(6), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .mode_i(mode_b), .code_i(code_b), .led(led_b), .tick(tick_b));
  led_status #(.NUM_LEDS(2), .TICK_DIV(2)) dut_c (
    .clk(clk), .rst_n(rst_c), .mode_i(mode_c), .code_i(code_c), .led(led_c), .tick(tick_c));
  led_status #(.NUM_LEDS(1), .TICK_DIV(128)) dut_d (
    .clk(clk), .rst_n(rst_d), .mode_i(mode_d), .code_i(code_d), .led(led_d), .tick(tick_d));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int c_base, c_pcode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp_v);
    end
  endtask

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      0:       return {27'd0, tick_a, led_a};
      1:       return {25'd0, tick_b, led_b};
      2:       return {29'd0, tick_c, led_c};
      default: return {30'd0, tick_d, led_d};
    endcase
  endfunction

  // Push the expectation for the coming edge, then pop it against the DUT after that edge.
  task automatic step(input int sel, input string tag, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    check(tag, get_out(sel), exp_q.pop_front());
  endtask

  function automatic int duty_of(input int p);
    return (p < 128) ? p : 255 - p;
  endfunction

  task automatic test_a();
    logic tk;
    mode_a = {4{3'd1}};
    rst_a  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      step(0, "a_reset", 32'd0);
      @(negedge clk);
    end
    rst_a = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tk = ((n % 4) == 0);
      step(0, "a_tick", {27'd0, tk, 4'hF});
      @(negedge clk);
    end
  endtask

  task automatic test_b();
    int m;
    logic [7:0] ph;
    logic b4, c0;
    mode_b = {3'd6, 3'd5, 3'd3, 3'd2, 3'd1, 3'd0};
    rst_b  = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      if (n == 301) mode_b[2:0] = 3'd1;
      m  = n - 1;
      ph = 8'(m % 256);
`ifdef LED_STATUS_BREATHE_EN
      b4 = ((m % 128) < duty_of(m % 256));
`else
      b4 = ph[7];
`endif
      c0 = (mode_b[2:0] == 3'd1);
      step(1, "b_modes", {25'd0, 1'b1, 1'b0, b4, ph[5], ph[7], 1'b1, c0});
      @(negedge clk);
    end
  endtask

  task automatic c_model(input int n, output logic [31:0] e);
    int m, u;
    logic hi, tk;
    m = n - 1;
    while (m - c_base >= 66 + 32 * c_pcode) begin
      c_base  += 66 + 32 * c_pcode;
      c_pcode  = int'(code_c[3:0]);
    end
    u  = m - c_base;
    hi = (u >= 2) && ((u - 2) < 32 * c_pcode) && (((u - 2) % 32) < 16);
    tk = ((n % 2) == 0);
    e  = {29'd0, tk, 1'b0, hi};
  endtask

  task automatic test_c();
    logic [31:0] e;
    mode_c = {3'd4, 3'd4};
    code_c = {4'd0, 4'd3};
    rst_c  = 1'b0;
    repeat (3) @(negedge clk);
    rst_c   = 1'b1;
    c_base  = 0;
    c_pcode = 3;
    for (int n = 1; n <= 40; n++) begin
      c_model(n, e);
      step(2, "c_code3_pre", e);
      @(negedge clk);
    end
    // Abort in the middle of the second pulse: output must drop without a clock edge.
    exp_q.push_back(32'd0);
    rst_c = 1'b0;
    #1;
    check("c_async_rst", get_out(2), exp_q.pop_front());
    repeat (3) @(negedge clk);
    rst_c   = 1'b1;
    c_base  = 0;
    c_pcode = 3;
    for (int n = 1; n <= 450; n++) begin
      if (n == 10) code_c[3:0] = 4'd1;
      c_model(n, e);
      step(2, "c_code_seq", e);
      @(negedge clk);
    end
  endtask

  task automatic test_d();
    int m, p;
    logic hi, tk;
    int hi_cnt[256];
    for (int i = 0; i < 256; i++) hi_cnt[i] = 0;
    mode_d = 3'd5;
    rst_d  = 1'b0;
    repeat (3) @(negedge clk);
    rst_d = 1'b1;
    for (int n = 1; n <= 256 * 128; n++) begin
      m = n - 1;
      p = (m / 128) % 256;
`ifdef LED_STATUS_BREATHE_EN
      hi = ((m % 128) < duty_of(p));
`else
      hi = (p >= 128);
`endif
      tk = ((n % 128) == 0);
      step(3, "d_breathe", {30'd0, tk, hi});
      if (led_d[0]) hi_cnt[p]++;
      @(negedge clk);
    end
`ifdef LED_STATUS_BREATHE_EN
    check("d_win_p0",   32'(hi_cnt[0]),   32'd0);
    check("d_win_p127", 32'(hi_cnt[127]), 32'd127);
    check("d_win_p128", 32'(hi_cnt[128]), 32'd127);
    check("d_win_p64",  32'(hi_cnt[64]),  32'd64);
`else
    check("d_win_p0",   32'(hi_cnt[0]),   32'd0);
    check("d_win_p127", 32'(hi_cnt[127]), 32'd0);
    check("d_win_p128", 32'(hi_cnt[128]), 32'd128);
    check("d_win_p255", 32'(hi_cnt[255]), 32'd128);
`endif
  endtask

  initial begin
    test_a();
    test_b();
    test_c();
    test_d();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
